coinc_acq_sequencer: RTL and testbench

Acquisition controller that sequences the coincidence detector datapath: drives its Restart/Enable/nCycles controls, runs a programmable number of fixed-length acquisition windows, and pulses a snapshot strobe after each window once the detector pipeline has drained. It sits between the host-side control registers and the detector top wrapper, replacing direct host toggling of Restart/Enable.

---
 rtl/coinc_acq_sequencer_pkg.sv | 17 +
 rtl/coinc_acq_sequencer_if.sv | 30 +++
 rtl/coinc_acq_sequencer_down_counter.sv | 33 +++
 rtl/coinc_acq_sequencer.sv | 140 ++++++++++++++
 tb/tb_coinc_acq_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/coinc_acq_sequencer_pkg.sv
// Shared types and constants for the coincidence acquisition sequencer.
package coinc_acq_pkg;

  // Sequencer states; one full window is ARM -> RUN -> DRAIN -> LATCH.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    LATCH   = 3'd4,
    RESTART = 3'd5
  } acq_state_e;

  // Detector pipeline depth: cycles between Enable falling and counters settling.
  localparam int DRAIN_CYC_DEFAULT = 4;

endpackage : coinc_acq_pkg

// File: rtl/coinc_acq_sequencer_if.sv
// Host-side control and detector-side control bundle of the acquisition sequencer.
interface coinc_acq_sequencer_if #(
  parameter int NBITS = 32,
  parameter int RUNW  = 16
);
  logic             Start_i;
  logic             Abort_i;
  logic [NBITS-1:0] nCycles_i;
  logic [RUNW-1:0]  Runs_i;
  logic             Restart_o;
  logic             Enable_o;
  logic [NBITS-1:0] nCycles_o;
  logic             Snap_o;
  logic [RUNW-1:0]  RunIdx_o;
  logic             Busy_o;
  logic             Done_o;
  logic             Aborted_o;

  // Host / stimulus side
  modport master (
    output Start_i, Abort_i, nCycles_i, Runs_i,
    input  Restart_o, Enable_o, nCycles_o, Snap_o, RunIdx_o, Busy_o, Done_o, Aborted_o
  );

  // Sequencer side
  modport slave (
    input  Start_i, Abort_i, nCycles_i, Runs_i,
    output Restart_o, Enable_o, nCycles_o, Snap_o, RunIdx_o, Busy_o, Done_o, Aborted_o
  );
endinterface : coinc_acq_sequencer_if

// File: rtl/coinc_acq_sequencer_down_counter.sv
// Loadable down-counter shared by the RUN window count and the DRAIN count.
module acq_down_counter #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [NBITS-1:0] i_load_val,
  input  logic             i_en,
  output logic [NBITS-1:0] o_count,
  output logic             o_last,
  output logic             o_zero
);

  logic [NBITS-1:0] r_count;

  // Load has priority over decrement; the count parks at zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - NBITS'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == NBITS'(1));
  assign o_zero  = (r_count == '0);

endmodule : acq_down_counter

// File: rtl/coinc_acq_sequencer.sv
// Acquisition sequencer: drives detector Restart/Enable/nCycles through a
// programmable number of fixed-length windows and strobes Snap after each drain.
module coinc_acq_sequencer
  import coinc_acq_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT,
  parameter int RUNW      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  coinc_acq_sequencer_if.slave  bus
);

  acq_state_e       r_state, w_next;
  logic [NBITS-1:0] r_ncycles;
  logic [RUNW-1:0]  r_runs, r_run_idx;
  logic             r_done, r_aborted;
  logic             r_restart, r_enable, r_snap, r_busy;
  logic             w_restart, w_enable, w_snap, w_busy;
  logic             w_accept, w_abort, w_more;
  logic             w_cnt_load, w_cnt_en, w_cnt_last, w_cnt_zero;
  logic [NBITS-1:0] w_cnt_val, w_cnt_count;

  assign w_accept = (r_state == IDLE) && bus.Start_i;
  assign w_abort  = (r_state != IDLE) && bus.Abort_i;
  // Another window follows unless a finite run count has just been reached.
  assign w_more   = (r_runs == '0) || (r_run_idx < (r_runs - RUNW'(1)));

  acq_down_counter #(.NBITS(NBITS)) u_cnt (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .o_count    (w_cnt_count),
    .o_last     (w_cnt_last),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort overrides every other transition.
  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.Start_i) w_next = ARM;
      ARM:     w_next = (r_ncycles == '0) ? DRAIN : RUN;
      RUN:     if (w_cnt_last) w_next = DRAIN;
      DRAIN:   if (w_cnt_last) w_next = LATCH;
      LATCH:   w_next = w_more ? RESTART : IDLE;
      RESTART: w_next = ARM;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  // Counter control: ARM loads the window length, the last RUN cycle loads the drain length.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_cnt_val  = NBITS'(DRAIN_CYC);
    case (r_state)
      ARM: begin
        w_cnt_load = 1'b1;
        if (r_ncycles != '0) w_cnt_val = r_ncycles;
      end
      RUN: begin
        w_cnt_load = w_cnt_last;
        w_cnt_en   = !w_cnt_last;
      end
      DRAIN:   w_cnt_en = 1'b1;
      default: ;
    endcase
  end

  // Output decode from the next state, so the registered outputs track the state.
  always_comb begin
    w_restart = (w_next == IDLE) || (w_next == RESTART);
    w_enable  = (w_next == RUN);
    w_snap    = (w_next == LATCH);
    w_busy    = (w_next != IDLE);
  end

  // Output registers for the detector controls.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_restart <= 1'b1;
      r_enable  <= 1'b0;
      r_snap    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_restart <= w_restart;
      r_enable  <= w_enable;
      r_snap    <= w_snap;
      r_busy    <= w_busy;
    end
  end

  // Configuration latch, run index and sticky status flags.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ncycles <= '0;
      r_runs    <= '0;
      r_run_idx <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_ncycles <= bus.nCycles_i;
      r_runs    <= bus.Runs_i;
      r_run_idx <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_aborted <= 1'b1;
    end else if (r_state == LATCH) begin
      if (w_more) r_run_idx <= r_run_idx + RUNW'(1);
      else        r_done    <= 1'b1;
    end
  end

  assign bus.Restart_o = r_restart;
  assign bus.Enable_o  = r_enable;
  assign bus.nCycles_o = r_ncycles;
  assign bus.Snap_o    = r_snap;
  assign bus.RunIdx_o  = r_run_idx;
  assign bus.Busy_o    = r_busy;
  assign bus.Done_o    = r_done;
  assign bus.Aborted_o = r_aborted;

  // Counter value and zero flag are observed only through the last flag here.
  logic w_unused;
  assign w_unused = ^{w_cnt_count, w_cnt_zero};

endmodule : coinc_acq_sequencer

// File: tb/tb_coinc_acq_sequencer.sv
// Directed bench for coinc_acq_sequencer: window timing, multi-run, zero-length,
// abort, ignored re-start and asynchronous reset.
module tb_coinc_acq_sequencer;

  localparam int NBITS = 32;
  localparam int RUNW  = 16;
  localparam int D     = 4;

  logic Clk;
  logic Rst_n;

  coinc_acq_sequencer_if #(.NBITS(NBITS), .RUNW(RUNW)) bus ();

  coinc_acq_sequencer #(.NBITS(NBITS), .DRAIN_CYC(D), .RUNW(RUNW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-acquisition observations; k counts cycles after the Start cycle T.
  int k, end_k, en_cnt, en_rise, first_en, snap_cnt, restart_cnt;
  int snap_k   [8];
  int snap_idx [8];
  logic arm_restart, prev_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Start an acquisition, optionally abort at cycle abort_at or re-pulse Start
  // at cycle restart_at, and record what the outputs did until Busy falls.
  task automatic run_acq(input logic [NBITS-1:0] n, input logic [RUNW-1:0] runs,
                         input bit abort_with_start, input int abort_at,
                         input int restart_at, input int budget);
    bus.nCycles_i = n;
    bus.Runs_i    = runs;
    bus.Start_i   = 1'b1;
    bus.Abort_i   = abort_with_start;
    tick();
    bus.Start_i   = 1'b0;
    bus.Abort_i   = 1'b0;
    bus.nCycles_i = 777;
    bus.Runs_i    = 5;
    en_cnt = 0; en_rise = 0; first_en = 0; snap_cnt = 0; restart_cnt = 0;
    prev_en = 1'b0; arm_restart = 1'b1;
    k = 1;
    while (bus.Busy_o && k <= budget) begin
      if (k == 1) arm_restart = bus.Restart_o;
      if (bus.Enable_o) begin
        en_cnt++;
        if (!prev_en) en_rise++;
        if (first_en == 0) first_en = k;
      end
      if (bus.Snap_o && snap_cnt < 8) begin
        snap_k[snap_cnt]   = k;
        snap_idx[snap_cnt] = int'(bus.RunIdx_o);
        snap_cnt++;
      end
      if (bus.Restart_o) restart_cnt++;
      prev_en = bus.Enable_o;
      if (k == abort_at) bus.Abort_i = 1'b1;
      if (k == restart_at) begin
        bus.Start_i   = 1'b1;
        bus.nCycles_i = 99;
      end
      tick();
      bus.Abort_i = 1'b0;
      bus.Start_i = 1'b0;
      k++;
    end
    end_k = k;
    if (k > budget) check("busy_timeout", 64'(bus.Busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int quiet_snaps;
    Rst_n         = 1'b0;
    bus.Start_i   = 1'b0;
    bus.Abort_i   = 1'b0;
    bus.nCycles_i = '0;
    bus.Runs_i    = '0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_restart", 64'(bus.Restart_o), 1);
    check("rst_enable",  64'(bus.Enable_o),  0);
    check("rst_ncycles", 64'(bus.nCycles_o), 0);
    check("rst_snap",    64'(bus.Snap_o),    0);
    check("rst_runidx",  64'(bus.RunIdx_o),  0);
    check("rst_busy",    64'(bus.Busy_o),    0);
    check("rst_done",    64'(bus.Done_o),    0);
    check("rst_aborted", 64'(bus.Aborted_o), 0);

    // Single 50-cycle window
    run_acq(50, 1, 1'b0, 0, 0, 200);
    check("t1_arm_restart", 64'(arm_restart), 0);
    check("t1_first_en",    first_en, 2);
    check("t1_en_cnt",      en_cnt,   50);
    check("t1_en_rise",     en_rise,  1);
    check("t1_snap_cnt",    snap_cnt, 1);
    check("t1_snap_k",      snap_k[0], 2 + 50 + D);
    check("t1_snap_after_en", snap_k[0] - first_en, 50 + D);
    check("t1_end_k",       end_k,    3 + 50 + D);
    check("t1_done",        64'(bus.Done_o),    1);
    check("t1_aborted",     64'(bus.Aborted_o), 0);
    check("t1_ncycles_o",   64'(bus.nCycles_o), 50);
    check("t1_idle_restart", 64'(bus.Restart_o), 1);

    // Three 10-cycle windows; each window period is ARM+RUN+DRAIN+LATCH+RESTART
    run_acq(10, 3, 1'b0, 0, 0, 200);
    check("t2_en_cnt",    en_cnt,      30);
    check("t2_en_rise",   en_rise,     3);
    check("t2_restarts",  restart_cnt, 2);
    check("t2_snap_cnt",  snap_cnt,    3);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("t2_snap_k%0d", j),   snap_k[j],   16 + j * 17);
      check($sformatf("t2_snap_idx%0d", j), snap_idx[j], j);
    end
    check("t2_end_k",   end_k, 51);
    check("t2_runidx",  64'(bus.RunIdx_o), 2);
    check("t2_done",    64'(bus.Done_o),   1);

    // Zero-length window, with Abort_i alongside Start_i in IDLE (Start wins)
    run_acq(0, 1, 1'b1, 0, 0, 50);
    check("t3_en_cnt",   en_cnt,    0);
    check("t3_snap_cnt", snap_cnt,  1);
    check("t3_snap_k",   snap_k[0], 2 + D);
    check("t3_end_k",    end_k,     3 + D);
    check("t3_done",     64'(bus.Done_o),    1);
    check("t3_aborted",  64'(bus.Aborted_o), 0);

    // Continuous mode, abort in 4th RUN cycle of window 2 (k = 13 + 1 + 3)
    run_acq(5, 0, 1'b0, 17, 0, 100);
    check("t4_end_k",    end_k,    18);
    check("t4_snap_cnt", snap_cnt, 1);
    check("t4_en_cnt",   en_cnt,   9);
    check("t4_restart",  64'(bus.Restart_o), 1);
    check("t4_enable",   64'(bus.Enable_o),  0);
    check("t4_aborted",  64'(bus.Aborted_o), 1);
    check("t4_done",     64'(bus.Done_o),    0);
    check("t4_runidx",   64'(bus.RunIdx_o),  1);
    quiet_snaps = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Snap_o || bus.Busy_o) quiet_snaps++;
      tick();
    end
    check("t4_quiet", quiet_snaps, 0);

    // Start re-pulsed mid-window with a different length is ignored
    run_acq(20, 1, 1'b0, 0, 5, 100);
    check("t5_en_cnt",   en_cnt,    20);
    check("t5_snap_k",   snap_k[0], 2 + 20 + D);
    check("t5_end_k",    end_k,     3 + 20 + D);
    check("t5_ncycles",  64'(bus.nCycles_o), 20);
    check("t5_aborted",  64'(bus.Aborted_o), 0);

    // Asynchronous reset during DRAIN (N=8: DRAIN spans k=10..13)
    bus.nCycles_i = 8;
    bus.Runs_i    = 1;
    bus.Start_i   = 1'b1;
    tick();
    bus.Start_i   = 1'b0;
    repeat (10) tick();
    check("t6_pre_busy",   64'(bus.Busy_o),   1);
    check("t6_pre_enable", 64'(bus.Enable_o), 0);
    #2;
    Rst_n = 1'b0;
    #1;
    check("t6_restart", 64'(bus.Restart_o), 1);
    check("t6_enable",  64'(bus.Enable_o),  0);
    check("t6_ncycles", 64'(bus.nCycles_o), 0);
    check("t6_snap",    64'(bus.Snap_o),    0);
    check("t6_busy",    64'(bus.Busy_o),    0);
    check("t6_runidx",  64'(bus.RunIdx_o),  0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    run_acq(3, 1, 1'b0, 0, 0, 50);
    check("t6_post_en_cnt", en_cnt,    3);
    check("t6_post_snap_k", snap_k[0], 2 + 3 + D);
    check("t6_post_end_k",  end_k,     3 + 3 + D);
    check("t6_post_done",   64'(bus.Done_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_coinc_acq_sequencer
